// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared FSM states, default depth and legal LATENCY range
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
  localparam int DEPTH_DEF = 512;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
endpackage

// File: rtl/memory_responder_if.sv
// memory_responder_if: datapath memory port bundle
//   master drives addr/wdata/read/write; slave returns rdata/done/busy/err
interface memory_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic read;
  logic write;
  logic done;
  logic busy;
  logic err;
  modport master(output addr, wdata, read, write, input rdata, done, busy, err);
  modport slave(input addr, wdata, read, write, output rdata, done, busy, err);
endinterface

// File: rtl/memory_responder_mem_array.sv
// mem_array: single-port synchronous word storage with registered read port
//   clk/clr: clock and async reset (clears only the read register, never the storage)
//   we/re: write/read enables; addr, wdata in; rdata registered out, holds between reads
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEPTH_DEF),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk or posedge clr)
    if (clr) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/memory_responder.sv
// memory_responder: latency-programmable memory side of the MAR/MDR port
//   clk/clr: clock and async active-high reset
//   bus (slave): addr/wdata/read/write requests in; rdata/done/busy/err registered out
module memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEPTH_DEF),
  parameter int DATA_W = 32,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic clr,
  memory_responder_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_chk
    $error("memory_responder: LATENCY out of range");
  end
  state_t st;
  logic [CW-1:0] cnt;
  logic op_wr;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic fire;
  // the access happens on the same edge that moves WAIT into RESP
  assign fire = st == WAIT && cnt == '0;
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .clr(clr),
    .we(fire && op_wr),
    .re(fire && !op_wr),
    .addr(a_q),
    .wdata(d_q),
    .rdata(bus.rdata)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      st <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      a_q <= '0;
      d_q <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      case (st)
        IDLE:
          if (bus.read ^ bus.write) begin
            st <= WAIT;
            cnt <= CW'(LATENCY - 1);
            op_wr <= bus.write;
            a_q <= bus.addr;
            d_q <= bus.wdata;
            bus.busy <= 1'b1;
          end else if (bus.read && bus.write) begin
            st <= HOLD;
            bus.err <= 1'b1;
          end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            st <= RESP;
            bus.done <= 1'b1;
          end
        end
        RESP: begin
          st <= HOLD;
          bus.busy <= 1'b0;
        end
        HOLD:
          if (!bus.read && !bus.write) st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: two responders (LATENCY 2 and 1) on shared stimulus vs a timestamp-based model
module tb_memory_responder;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int L0 = 2;
  localparam int L1 = 1;
  logic clk = 0;
  logic clr = 0;
  logic r = 0;
  logic w = 0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] d = '0;
  always #5 clk = ~clk;
  memory_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  memory_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  assign bus0.read = r;
  assign bus0.write = w;
  assign bus0.addr = a;
  assign bus0.wdata = d;
  assign bus1.read = r;
  assign bus1.write = w;
  assign bus1.addr = a;
  assign bus1.wdata = d;
  memory_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L0)) dut0 (.clk(clk), .clr(clr), .bus(bus0.slave));
  memory_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L1)) dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));
  logic [DW-1:0] q_rd [2];
  logic q_done [2];
  logic q_busy [2];
  logic q_err [2];
  assign q_rd[0] = bus0.rdata;
  assign q_rd[1] = bus1.rdata;
  assign q_done[0] = bus0.done;
  assign q_done[1] = bus1.done;
  assign q_busy[0] = bus0.busy;
  assign q_busy[1] = bus1.busy;
  assign q_err[0] = bus0.err;
  assign q_err[1] = bus1.err;

  function automatic int lat(input int k);
    return k == 0 ? L0 : L1;
  endfunction

  // model: phase 0 idle, 1 access in flight (timed from acceptance cycle), 2 waiting for strobes low
  int cyc = 0;
  int ph [2];
  int acc [2];
  logic mwr [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];
  logic [DW-1:0] mem [2][512];
  logic [DW-1:0] e_rd [2];
  logic e_done [2];
  logic e_busy [2];
  logic e_err [2];
  initial
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0;
      e_rd[k] = '0;
      e_done[k] = 0;
      e_busy[k] = 0;
      e_err[k] = 0;
      for (int i = 0; i < 512; i++) mem[k][i] = '0;
    end
  always @(posedge clk or posedge clr)
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0;
        e_rd[k] = '0;
        e_done[k] = 0;
        e_busy[k] = 0;
        e_err[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        e_done[k] = 0;
        e_err[k] = 0;
        if (ph[k] == 0) begin
          if (r ^ w) begin
            ph[k] = 1;
            acc[k] = cyc;
            mwr[k] = w;
            ma[k] = a;
            md[k] = d;
            e_busy[k] = 1;
          end else if (r && w) begin
            e_err[k] = 1;
            ph[k] = 2;
          end
        end else if (ph[k] == 1) begin
          if (cyc == acc[k] + lat(k)) begin
            if (mwr[k]) mem[k][ma[k]] = md[k];
            else e_rd[k] = mem[k][ma[k]];
            e_done[k] = 1;
          end else if (cyc == acc[k] + lat(k) + 1) begin
            e_busy[k] = 0;
            ph[k] = 2;
          end
        end else if (!r && !w) ph[k] = 0;
      end
    end

  int checks = 0;
  int fails = 0;
  logic en = 0;
  int ndone [2] = '{0, 0};
  int nerr [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  logic [DW-1:0] last_rd [2];

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (en)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rdata%0d", k), q_rd[k], e_rd[k]);
        chk($sformatf("done%0d", k), 32'(q_done[k]), 32'(e_done[k]));
        chk($sformatf("busy%0d", k), 32'(q_busy[k]), 32'(e_busy[k]));
        chk($sformatf("err%0d", k), 32'(q_err[k]), 32'(e_err[k]));
        if (q_done[k] === 1'b1) begin
          ndone[k]++;
          last_rd[k] = q_rd[k];
          done_cyc[k] = cyc;
        end
        if (q_err[k] === 1'b1) nerr[k]++;
      end
  end

  // one request held for `hold` sampled edges, then idle long enough for both DUTs to settle
  task automatic op(input string nm, input logic rr, input logic ww, input logic [AW-1:0] aa,
                    input logic [DW-1:0] dd, input int hold, input int exp_n, input logic [DW-1:0] exp_rd);
    int n0 [2];
    int t;
    n0 = ndone;
    @(negedge clk);
    r = rr;
    w = ww;
    a = aa;
    d = dd;
    @(posedge clk);
    #1 t = cyc;
    repeat (hold) @(negedge clk);
    r = 0;
    w = 0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ndone%0d", nm, k), 32'(ndone[k] - n0[k]), 32'(exp_n));
      if (exp_n == 1) chk($sformatf("%s_lat%0d", nm, k), 32'(done_cyc[k] - t), 32'(lat(k)));
      if (exp_n == 1 && rr && !ww) chk($sformatf("%s_rd%0d", nm, k), last_rd[k], exp_rd);
    end
  endtask

  initial begin
    int e0 [2];
    int n0 [2];
    #2 clr = 1;
    en = 1;
    repeat (2) @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rdata%0d", k), q_rd[k], 32'h0);
      chk($sformatf("rst_busy%0d", k), 32'(q_busy[k]), 32'h0);
    end
    @(negedge clk);
    clr = 0;
    op("wr5", 0, 1, 9'h005, 32'h0000_0012, 1, 1, 32'h0);
    op("rd5", 1, 0, 9'h005, 32'h0, 1, 1, 32'h0000_0012);
    op("rd1ff", 1, 0, 9'h1FF, 32'h0, 1, 1, 32'h0);
    e0 = nerr;
    op("conf", 1, 1, 9'h003, 32'hDEAD_BEEF, 1, 0, 32'h0);
    for (int k = 0; k < 2; k++) chk($sformatf("conf_err%0d", k), 32'(nerr[k] - e0[k]), 32'h1);
    op("rd3", 1, 0, 9'h003, 32'h0, 1, 1, 32'h0);
    op("wr4", 0, 1, 9'h004, 32'hA5A5_0004, 1, 1, 32'h0);
    op("wr6", 0, 1, 9'h006, 32'h0000_0666, 1, 1, 32'h0);
    n0 = ndone;
    @(negedge clk);
    r = 1;
    a = 9'h004;
    @(negedge clk);
    a = 9'h006;
    repeat (9) @(negedge clk);
    r = 0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold_ndone%0d", k), 32'(ndone[k] - n0[k]), 32'h1);
      chk($sformatf("hold_rd%0d", k), last_rd[k], 32'hA5A5_0004);
    end
    @(negedge clk);
    w = 1;
    a = 9'h007;
    d = 32'h0000_0018;
    @(negedge clk);
    w = 0;
    clr = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mid_rdata%0d", k), q_rd[k], 32'h0);
      chk($sformatf("mid_done%0d", k), 32'(q_done[k]), 32'h0);
      chk($sformatf("mid_busy%0d", k), 32'(q_busy[k]), 32'h0);
      chk($sformatf("mid_err%0d", k), 32'(q_err[k]), 32'h0);
    end
    @(negedge clk);
    clr = 0;
    op("rd7", 1, 0, 9'h007, 32'h0, 1, 1, 32'h0);
    op("wr2", 0, 1, 9'h002, 32'h0000_0014, 1, 1, 32'h0);
    op("rd2", 1, 0, 9'h002, 32'h0, 1, 1, 32'h0000_0014);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      clr = $urandom_range(99) == 0;
      r = $urandom_range(3) == 0;
      w = $urandom_range(3) == 0;
      a = $urandom_range(2) == 0 ? AW'($urandom) : AW'($urandom_range(7));
      d = $urandom;
    end
    @(negedge clk);
    clr = 0;
    r = 0;
    w = 0;
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
